// File: rtl/rv32i_types.sv
// Shared core types: issue-port record and default scheduler sizing.
// Sizing constants match the default alu_issue_scheduler build.
package rv32i_types;
  localparam int RS_SIZE_DEF = 8;
  localparam int ALU_PORTS   = 2;
  localparam int RS_IDX_W    = $clog2(RS_SIZE_DEF);

  typedef struct packed {
    logic                valid;
    logic [RS_IDX_W-1:0] idx;
  } issue_port_t;
endpackage

// File: rtl/alu_issue_scheduler_if.sv
// RS/ALU side signal bundle of the ALU issue scheduler.
// The scheduler uses the master modport; the RS/ALU environment uses slave.
interface alu_issue_scheduler_if #(
  parameter int RS_SIZE = 8,
  parameter int NUM_ALU = 2,
  parameter int IDX_W   = $clog2(RS_SIZE)
);
  logic                             flush;
  logic [RS_SIZE-1:0]               rs_ready;
  logic [RS_SIZE-1:0]               done_mask;
  logic [NUM_ALU-1:0]               alu_ready;
  logic [NUM_ALU-1:0]               issue_valid;
  logic [NUM_ALU-1:0][IDX_W-1:0]    issue_idx;
  logic [RS_SIZE-1:0]               inflight;

  modport master (
    input  flush, rs_ready, done_mask, alu_ready,
    output issue_valid, issue_idx, inflight
  );

  modport slave (
    output flush, rs_ready, done_mask, alu_ready,
    input  issue_valid, issue_idx, inflight
  );
endinterface

// File: rtl/rr_picker.sv
// Circular priority encoder: first set request bit at or after start.
module rr_picker #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] pos;

  // N is a power of two, so the W-bit add wraps the scan circularly.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = start + W'(k);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end
endmodule

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue of ready RS entries onto NUM_ALU valid/ready ports.
// Optional stats counters are enabled with ALU_ISSUE_SCHED_STATS_EN.
module alu_issue_scheduler
  import rv32i_types::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int NUM_ALU = ALU_PORTS,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input  logic clk,
  input  logic rst,
  alu_issue_scheduler_if.master bus
`ifdef ALU_ISSUE_SCHED_STATS_EN
  ,
  output logic [31:0] stat_issues,
  output logic [31:0] stat_stalls
`endif
);
  logic [IDX_W-1:0]              rr_ptr, rr_d;
  logic [RS_SIZE-1:0]            inflight_q, grant_mask;
  logic [NUM_ALU-1:0]            valid_q, free, found, grant;
  logic [NUM_ALU-1:0][IDX_W-1:0] idx_q, pick;
  logic [NUM_ALU:0][RS_SIZE-1:0] req;

  assign req[0] = bus.rs_ready & ~inflight_q & ~bus.done_mask;

  // Each port sees the candidates left over by lower-numbered ports.
  for (genvar p = 0; p < NUM_ALU; p++) begin : g_port
    rr_picker #(.N(RS_SIZE), .W(IDX_W)) u_pick (
      .req   (req[p]),
      .start (rr_ptr),
      .found (found[p]),
      .idx   (pick[p])
    );
    assign free[p]    = !valid_q[p] || bus.alu_ready[p];
    assign grant[p]   = free[p] && found[p];
    assign req[p+1]   = grant[p] ? (req[p] & ~(RS_SIZE'(1) << pick[p])) : req[p];
  end

  always_comb begin
    grant_mask = '0;
    rr_d       = rr_ptr;
    for (int p = 0; p < NUM_ALU; p++) begin
      if (grant[p]) begin
        grant_mask[pick[p]] = 1'b1;
        rr_d                = pick[p] + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      idx_q      <= '0;
      inflight_q <= '0;
      rr_ptr     <= '0;
    end else if (bus.flush) begin
      valid_q    <= '0;
      inflight_q <= '0;
      rr_ptr     <= '0;
    end else begin
      inflight_q <= (inflight_q & ~bus.done_mask) | grant_mask;
      rr_ptr     <= rr_d;
      for (int p = 0; p < NUM_ALU; p++) begin
        if (free[p]) begin
          valid_q[p] <= grant[p];
          if (grant[p]) idx_q[p] <= pick[p];
        end
      end
    end
  end

  assign bus.issue_valid = valid_q;
  assign bus.issue_idx   = idx_q;
  assign bus.inflight    = inflight_q;

`ifdef ALU_ISSUE_SCHED_STATS_EN
  logic [31:0] hs_cnt;
  logic [32:0] issues_sum;
  logic        any_stall;

  always_comb begin
    hs_cnt = '0;
    for (int p = 0; p < NUM_ALU; p++) hs_cnt = hs_cnt + 32'(valid_q[p] && bus.alu_ready[p]);
  end
  assign issues_sum = {1'b0, stat_issues} + {1'b0, hs_cnt};
  assign any_stall  = |(valid_q & ~bus.alu_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issues <= '0;
      stat_stalls <= '0;
    end else if (bus.flush) begin
      stat_issues <= '0;
      stat_stalls <= '0;
    end else begin
      stat_issues <= issues_sum[32] ? '1 : issues_sum[31:0];
      if (any_stall && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed self-checking bench for alu_issue_scheduler (default 8 entries, 2 ports).
module tb_alu_issue_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_issue_scheduler_if #(.RS_SIZE(8), .NUM_ALU(2), .IDX_W(3)) bus ();

`ifdef ALU_ISSUE_SCHED_STATS_EN
  logic [31:0] stat_issues, stat_stalls;
`endif

  alu_issue_scheduler #(.RS_SIZE(8), .NUM_ALU(2), .IDX_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ISSUE_SCHED_STATS_EN
    ,
    .stat_issues (stat_issues),
    .stat_stalls (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.rs_ready  = '0;
    bus.done_mask = '0;
    bus.alu_ready = '0;
  endtask

  task automatic do_flush();
    idle_inputs();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++; if (bus.issue_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", bus.issue_valid); end
    checks++; if (bus.issue_idx !== 6'd0) begin errors++; $display("FAIL reset_idx: got %h expected 0", bus.issue_idx); end
    checks++; if (bus.inflight !== 8'h00) begin errors++; $display("FAIL reset_inflight: got %h expected 00", bus.inflight); end
    checks++; if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr); end
`ifdef ALU_ISSUE_SCHED_STATS_EN
    checks++; if (stat_issues !== 32'd0 || stat_stalls !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_issues, stat_stalls); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    idle_inputs();
    bus.rs_ready  = 8'b0000_0101;
    bus.alu_ready = 2'b11;
    #1;
    checks++; if (bus.issue_valid !== 2'b00) begin errors++; $display("FAIL basic_latency: got %b expected 00", bus.issue_valid); end
    step();
    checks++; if (bus.issue_valid !== 2'b11) begin errors++; $display("FAIL basic_valid: got %b expected 11", bus.issue_valid); end
    checks++; if (bus.issue_idx[0] !== 3'd0) begin errors++; $display("FAIL basic_idx0: got %0d expected 0", bus.issue_idx[0]); end
    checks++; if (bus.issue_idx[1] !== 3'd2) begin errors++; $display("FAIL basic_idx1: got %0d expected 2", bus.issue_idx[1]); end
    checks++; if (bus.inflight !== 8'h05) begin errors++; $display("FAIL basic_inflight: got %h expected 05", bus.inflight); end
    checks++; if (dut.rr_ptr !== 3'd3) begin errors++; $display("FAIL basic_rr_ptr: got %0d expected 3", dut.rr_ptr); end
    bus.rs_ready  = '0;
    bus.done_mask = 8'h05;
    step();
    checks++; if (bus.issue_valid !== 2'b00) begin errors++; $display("FAIL basic_drain_valid: got %b expected 00", bus.issue_valid); end
    checks++; if (bus.inflight !== 8'h00) begin errors++; $display("FAIL basic_drain_inflight: got %h expected 00", bus.inflight); end
    checks++; if (dut.rr_ptr !== 3'd3) begin errors++; $display("FAIL basic_rr_hold: got %0d expected 3", dut.rr_ptr); end
  endtask

  task automatic test_fairness();
    int          e0[5] = '{0, 2, 4, 6, 0};
    int          e1[5] = '{1, 3, 5, 7, 1};
    logic [7:0]  dm = 8'h00;
    do_flush();
    for (int i = 0; i < 5; i++) begin
      bus.rs_ready  = 8'hFF;
      bus.done_mask = dm;
      bus.alu_ready = 2'b11;
      step();
      dm = (8'h01 << e0[i]) | (8'h01 << e1[i]);
      checks++; if (bus.issue_valid !== 2'b11) begin errors++; $display("FAIL fair_valid[%0d]: got %b expected 11", i, bus.issue_valid); end
      checks++; if (bus.issue_idx[0] !== 3'(e0[i])) begin errors++; $display("FAIL fair_idx0[%0d]: got %0d expected %0d", i, bus.issue_idx[0], e0[i]); end
      checks++; if (bus.issue_idx[1] !== 3'(e1[i])) begin errors++; $display("FAIL fair_idx1[%0d]: got %0d expected %0d", i, bus.issue_idx[1], e1[i]); end
      checks++; if (bus.inflight !== dm) begin errors++; $display("FAIL fair_inflight[%0d]: got %h expected %h", i, bus.inflight, dm); end
    end
    checks++; if (dut.rr_ptr !== 3'd2) begin errors++; $display("FAIL fair_rr_ptr: got %0d expected 2", dut.rr_ptr); end
    bus.rs_ready  = '0;
    bus.done_mask = dm;
    step();
    bus.done_mask = '0;
  endtask

  task automatic test_backpressure();
    do_flush();
    bus.rs_ready  = 8'h08;
    bus.alu_ready = 2'b00;
    step();
    checks++; if (bus.issue_valid !== 2'b01 || bus.issue_idx[0] !== 3'd3) begin errors++; $display("FAIL bp_setup: got v=%b idx0=%0d expected v=01 idx0=3", bus.issue_valid, bus.issue_idx[0]); end
    bus.rs_ready  = 8'h28;
    bus.alu_ready = 2'b10;
    step();
    checks++; if (bus.issue_valid !== 2'b11 || bus.issue_idx[1] !== 3'd5) begin errors++; $display("FAIL bp_port1: got v=%b idx1=%0d expected v=11 idx1=5", bus.issue_valid, bus.issue_idx[1]); end
    checks++; if (bus.inflight !== 8'h28) begin errors++; $display("FAIL bp_inflight: got %h expected 28", bus.inflight); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.issue_valid !== 2'b01 || bus.issue_idx[0] !== 3'd3) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b idx0=%0d expected v=01 idx0=3", i, bus.issue_valid, bus.issue_idx[0]); end
    end
    bus.rs_ready  = 8'h68;
    bus.alu_ready = 2'b11;
    step();
    checks++; if (bus.issue_valid !== 2'b01 || bus.issue_idx[0] !== 3'd6) begin errors++; $display("FAIL bp_release: got v=%b idx0=%0d expected v=01 idx0=6", bus.issue_valid, bus.issue_idx[0]); end
    checks++; if (bus.inflight !== 8'h68) begin errors++; $display("FAIL bp_release_inflight: got %h expected 68", bus.inflight); end
    checks++; if (dut.rr_ptr !== 3'd7) begin errors++; $display("FAIL bp_rr_ptr: got %0d expected 7", dut.rr_ptr); end
    bus.rs_ready  = '0;
    bus.done_mask = 8'h68;
    step();
    bus.done_mask = '0;
  endtask

  task automatic test_no_double_issue();
    do_flush();
    bus.rs_ready  = 8'h02;
    bus.alu_ready = 2'b11;
    step();
    checks++; if (bus.issue_valid !== 2'b01 || bus.issue_idx[0] !== 3'd1) begin errors++; $display("FAIL nd_first: got v=%b idx0=%0d expected v=01 idx0=1", bus.issue_valid, bus.issue_idx[0]); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.issue_valid !== 2'b00 || bus.inflight !== 8'h02) begin errors++; $display("FAIL nd_hold[%0d]: got v=%b inflight=%h expected v=00 inflight=02", i, bus.issue_valid, bus.inflight); end
    end
    bus.done_mask = 8'h02;
    step();
    checks++; if (bus.issue_valid !== 2'b00 || bus.inflight !== 8'h00) begin errors++; $display("FAIL nd_done: got v=%b inflight=%h expected v=00 inflight=00", bus.issue_valid, bus.inflight); end
    bus.done_mask = '0;
    step();
    checks++; if (bus.issue_valid !== 2'b01 || bus.issue_idx[0] !== 3'd1 || bus.inflight !== 8'h02) begin errors++; $display("FAIL nd_reissue: got v=%b idx0=%0d inflight=%h expected v=01 idx0=1 inflight=02", bus.issue_valid, bus.issue_idx[0], bus.inflight); end
    bus.rs_ready  = '0;
    bus.done_mask = 8'h02;
    step();
    bus.done_mask = '0;
  endtask

  task automatic test_flush();
    do_flush();
    bus.rs_ready  = 8'hF0;
    bus.alu_ready = 2'b11;
    step();
    step();
    checks++; if (bus.inflight !== 8'hF0 || bus.issue_idx[0] !== 3'd6 || bus.issue_idx[1] !== 3'd7) begin errors++; $display("FAIL flush_setup: got inflight=%h idx=%0d,%0d expected F0 6,7", bus.inflight, bus.issue_idx[0], bus.issue_idx[1]); end
    bus.alu_ready = 2'b00;
    bus.rs_ready  = 8'hFF;
    bus.flush     = 1'b1;
    step();
    checks++; if (bus.issue_valid !== 2'b00) begin errors++; $display("FAIL flush_valid: got %b expected 00", bus.issue_valid); end
    checks++; if (bus.inflight !== 8'h00) begin errors++; $display("FAIL flush_inflight: got %h expected 00", bus.inflight); end
    checks++; if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL flush_rr_ptr: got %0d expected 0", dut.rr_ptr); end
    idle_inputs();
    step();
  endtask

`ifdef ALU_ISSUE_SCHED_STATS_EN
  task automatic test_stats();
    do_flush();
    bus.rs_ready  = 8'h03;
    bus.alu_ready = 2'b11;
    step();
    bus.rs_ready  = '0;
    bus.alu_ready = 2'b01;
    step();
    checks++; if (stat_issues !== 32'd1 || stat_stalls !== 32'd1) begin errors++; $display("FAIL stats_mid: got %0d/%0d expected 1/1", stat_issues, stat_stalls); end
    bus.alu_ready = 2'b11;
    step();
    checks++; if (stat_issues !== 32'd2 || stat_stalls !== 32'd1) begin errors++; $display("FAIL stats_end: got %0d/%0d expected 2/1", stat_issues, stat_stalls); end
    bus.done_mask = 8'h03;
    step();
    bus.done_mask = '0;
  endtask
`endif

  task automatic test_async_reset();
    idle_inputs();
    bus.rs_ready = 8'h01;
    step();
    step();
    checks++; if (bus.issue_valid !== 2'b01 || bus.inflight !== 8'h01) begin errors++; $display("FAIL ar_setup: got v=%b inflight=%h expected v=01 inflight=01", bus.issue_valid, bus.inflight); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.issue_valid !== 2'b00) begin errors++; $display("FAIL ar_valid: got %b expected 00", bus.issue_valid); end
    checks++; if (bus.inflight !== 8'h00) begin errors++; $display("FAIL ar_inflight: got %h expected 00", bus.inflight); end
    checks++; if (bus.issue_idx !== 6'd0) begin errors++; $display("FAIL ar_idx: got %h expected 0", bus.issue_idx); end
    checks++; if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL ar_rr_ptr: got %0d expected 0", dut.rr_ptr); end
`ifdef ALU_ISSUE_SCHED_STATS_EN
    checks++; if (stat_issues !== 32'd0 || stat_stalls !== 32'd0) begin errors++; $display("FAIL ar_stats: got %0d/%0d expected 0/0", stat_issues, stat_stalls); end
`endif
    #1;
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_fairness();
    test_backpressure();
    test_no_double_issue();
    test_flush();
`ifdef ALU_ISSUE_SCHED_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_scheduler.md
# alu_issue_scheduler

- Picks ready reservation-station entries and dispatches them to `NUM_ALU` execution ports.
- Sits between the ALU reservation station and the ALUs.
- Arbitrates round-robin across RS slots, so no ready entry starves.
- Tracks issued-but-unfinished entries so each entry issues exactly once.
- Holds each port's issue register stable until that ALU accepts it (valid/ready handshake).

## Interface
- `RS_SIZE`, default 8: number of RS entries; must be a power of 2, ≥ 2.
- `NUM_ALU`, default 2: number of execution ports, 1..`RS_SIZE`.
- `IDX_W`, default `$clog2(RS_SIZE)`: width of an RS index.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous squash of all scheduler state (branch mispredict).
- `rs_ready`  in  `RS_SIZE`  entry is valid and both operands are resolved.
- `done_mask`  in  `RS_SIZE`  ALU broadcast: entry i finished this cycle.
- `alu_ready`  in  `NUM_ALU`  port p accepts its issue register this cycle.
- `issue_valid`  out  `NUM_ALU`  port p holds an entry to execute.
- `issue_idx`  out  `NUM_ALU`×`IDX_W`  RS index presented on port p.
- `inflight`  out  `RS_SIZE`  entry i has been granted and is not yet done.

## Operation
- **Candidates:** `cand = rs_ready & ~inflight & ~done_mask`.
- **Free port:** port p is free when `!issue_valid[p] || alu_ready[p]`.
- **Grant order:** free ports are granted in ascending p.
  - Each grant takes the first set bit of `cand` scanning circularly from `rr_ptr`.
  - That bit is removed from `cand` before the next port is granted.
  - No entry is granted to two ports in the same cycle.
- **Granted port:** on the next edge, `issue_valid[p]` is set to 1, `issue_idx[p]` is loaded with the index, and `inflight[idx]` is set.
- **Free port with no candidate left:** `issue_valid[p]` goes to 0 if `alu_ready[p]`; otherwise the port was already idle.
- **Stalled port** (`issue_valid && !alu_ready`): `issue_valid` and `issue_idx` hold. No new grant is made to that port.
- **rr_ptr:** after any grant, becomes (highest-priority-order last granted index + 1) mod `RS_SIZE`. It is unchanged when nothing is granted.
- **Completion:** `done_mask[i]` clears `inflight[i]` on the next edge.
- **done_mask for a non-inflight entry:** no effect other than excluding that entry from candidates this cycle.
- **Flush:** at the edge where `flush` is high, `issue_valid`, `inflight` and `rr_ptr` are all cleared. `flush` overrides every grant and every completion in that cycle.
- **Fewer candidates than free ports:** the lowest-numbered free ports receive the grants.
- **All entries inflight, or none ready:** no grants; `rr_ptr` is unchanged.

## Timing
- **Reset values:**
  - `issue_valid` = 0.
  - `issue_idx` = 0 on all ports.
  - `inflight` = 0.
  - `rr_ptr` = 0.
  - Stats counters = 0.
- **Reset mid-stall:** state clears immediately and asynchronously. The pending issue is discarded.
- **Latency:**
  - An entry whose `rs_ready` rises in cycle N appears on a port in cycle N+1 at the earliest.
  - An entry accepted in cycle N can be replaced on that port in cycle N+1, giving a throughput of one issue per port per cycle.
- **Decision inputs:** grant logic is combinational in the current cycle from `rs_ready`, `done_mask`, `alu_ready` and `inflight`. All outputs are registered.
- **Port handshake:** the transfer happens in the cycle where `issue_valid && alu_ready` are both high.
- **Done and regrant:**
  - `done_mask[i]` and a regrant of i are never both effective in one cycle.
  - The RS refills slot i one cycle later, and i is then a fresh candidate.

## Configuration
- Macro: `ALU_ISSUE_SCHED_STATS_EN`.
- **Defined:** adds outputs `stat_issues` (32 b) and `stat_stalls` (32 b). Both saturate at all-ones and clear on `rst` or `flush`.
  - `stat_issues` increments by the number of handshakes completed that cycle.
  - `stat_stalls` increments by 1 in any cycle where some port has `issue_valid && !alu_ready`.
- **Undefined:** these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package `rv32i_types` gets:
  - `issue_port_t` = {`valid`, `idx[IDX_W]`}.
  - Constant `ALU_PORTS` (= 2) for top-level instantiation.
- Sub-module `rr_picker`: combinational circular priority encoder.
  - Inputs: request vector and start pointer.
  - Outputs: `found` and `idx`.
  - Instantiated once per port in a chain, with masked requests.

## Test plan
- **Basic ready and acceptance:** after reset, `rs_ready=8'b0000_0101` with both ALUs ready → cycle+1: port0 idx 0, port1 idx 2, `inflight=8'b0000_0101`, `rr_ptr=3`.
- **Fairness:** all 8 entries ready and re-marked ready via `done_mask` each cycle, NUM_ALU=2 → grants rotate 0,1 / 2,3 / 4,5 / 6,7 / 0,1, and no index is skipped.
- **Backpressure:** port0 holds idx 3 with `alu_ready[0]=0` for 4 cycles while entry 5 becomes ready → port0 stays at idx 3 and port1 issues idx 5. After `alu_ready[0]=1`, port0 takes the next candidate.
- **No double issue:** entry 1 stays `rs_ready` while inflight → it never reappears until `done_mask[1]`. Re-asserting `rs_ready[1]` after the done cycle → reissue one cycle later.
- **Flush:** ports stalled and `inflight=8'hF0` when `flush` pulses → next cycle `issue_valid=0`, `inflight=0`, `rr_ptr=0`. A simultaneous `rs_ready` is ignored that cycle.
- **Async reset mid-stall:** assert `rst` between clock edges → outputs go to 0 without waiting for a clock edge. With `ALU_ISSUE_SCHED_STATS_EN` defined, the counters also read 0.
